// File: rtl/div_unit.sv
// div_unit: iterative radix-2 signed/unsigned divider producing {remainder, quotient}
// Ports: clk/rst (async active-high); start_i, signed_i, opdata1_i (dividend),
// opdata2_i (divisor), annul_i in; result_o {rem, quo}, ready_o, busy_o, stall_o out.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               stall_o
);
  localparam logic [2:0] IDLE = 3'd0, ZERO = 3'd1, BUSY = 3'd2, FIX = 3'd3, DONE = 3'd4;
  logic [2:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] rem_q, rem_d, rem_sh, rem_sub;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, q_fix, r_fix, abs1, abs2;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic sgn_q, sgn_d, n1_q, n1_d, n2_q, n2_d, ready_q, ready_d, busy_q, busy_d, ge;
  // dvd_q doubles as the quotient: dividend bits shift out the top while quotient bits shift in
  assign abs1 = signed_i && opdata1_i[WIDTH-1] ? -opdata1_i : opdata1_i;
  assign abs2 = signed_i && opdata2_i[WIDTH-1] ? -opdata2_i : opdata2_i;
  assign rem_sh = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, dvs_q};
  assign ge = rem_sh >= {1'b0, dvs_q};
  assign q_fix = sgn_q && (n1_q ^ n2_q) ? -dvd_q : dvd_q;
  assign r_fix = sgn_q && n1_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    sgn_d = sgn_q;
    n1_d = n1_q;
    n2_d = n2_q;
    result_d = result_q;
    ready_d = ready_q;
    if (annul_i && state_q != IDLE) begin
      state_d = IDLE;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i && !annul_i) begin
          sgn_d = signed_i;
          n1_d = opdata1_i[WIDTH-1];
          n2_d = opdata2_i[WIDTH-1];
          if (opdata2_i == '0) state_d = ZERO;
          else begin
            dvd_d = abs1;
            dvs_d = abs2;
            rem_d = '0;
            cnt_d = '0;
            state_d = BUSY;
          end
        end
        ZERO: begin
          result_d = '0;
          ready_d = 1'b1;
          state_d = DONE;
        end
        BUSY: begin
          rem_d = ge ? rem_sub : rem_sh;
          dvd_d = {dvd_q[WIDTH-2:0], ge};
          cnt_d = cnt_q + CNT_W'(1);
          state_d = cnt_q == CNT_W'(WIDTH - 1) ? FIX : BUSY;
        end
        FIX: begin
          result_d = {r_fix, q_fix};
          ready_d = 1'b1;
          state_d = DONE;
        end
        DONE: if (!start_i) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = state_d == ZERO || state_d == BUSY || state_d == FIX;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      sgn_q <= 1'b0;
      n1_q <= 1'b0;
      n2_q <= 1'b0;
      result_q <= '0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      sgn_q <= sgn_d;
      n1_q <= n1_d;
      n2_q <= n2_d;
      result_q <= result_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
    end
  end
  assign result_o = result_q;
  assign ready_o = ready_q;
  assign busy_o = busy_q;
  assign stall_o = start_i & ~annul_i & ~ready_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven and sequence checks for div_unit at WIDTH=32
module tb_div_unit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sgn = 1'b0, annul = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [63:0] res;
  logic ready, busy, stall;
  int nvec = 0, nerr = 0;
  typedef struct packed {
    logic s;
    logic [31:0] a, b, q, r;
    logic z;
  } vec_t;
  vec_t tv [13];
  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .signed_i(sgn), .opdata1_i(a),
    .opdata2_i(b), .annul_i(annul), .result_o(res), .ready_o(ready),
    .busy_o(busy), .stall_o(stall)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask
  task automatic run(input vec_t v);
    int n = 0, nb = 0;
    @(negedge clk);
    start = 1'b1;
    sgn = v.s;
    a = v.a;
    b = v.b;
    #1 chk("stall_pre", 64'(stall), 64'd1);
    do begin
      @(posedge clk);
      #1 n++;
      if (busy) nb++;
      if (n == 1) begin
        a = $urandom;
        b = $urandom;
      end
    end while (!ready && n < 100);
    chk("latency", 64'(n), v.z ? 64'd2 : 64'd34);
    chk("busy_cycles", 64'(nb), v.z ? 64'd1 : 64'd33);
    chk("result", res, {v.r, v.q});
    chk("stall_done", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1 chk("ready_drop", 64'(ready), 64'd0);
  endtask
  initial begin
    logic [63:0] hold;
    bit bad;
    tv[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tv[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    tv[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    tv[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    tv[4]  = '{1'b0, 32'd5,          32'd0,          32'd0,          32'd0,          1'b1};
    tv[5]  = '{1'b0, 32'd0,          32'd9,          32'd0,          32'd0,          1'b0};
    tv[6]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    tv[7]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    tv[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
    tv[9]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
    tv[10] = '{1'b1, 32'd5,          32'd0,          32'd0,          32'd0,          1'b1};
    tv[11] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
    tv[12] = '{1'b0, 32'd1000,       32'd3,          32'd333,        32'd1,          1'b0};
    #1 chk("reset_async", {res[61:0], ready, busy}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("reset_state", {res[61:0], ready, busy}, 64'd0);
    for (int i = 0; i < 13; i++) run(tv[i]);
    // hold start past ready, then release
    @(negedge clk);
    start = 1'b1;
    sgn = 1'b0;
    a = 32'd9;
    b = 32'd4;
    for (int i = 0; i < 100 && !ready; i++) begin
      @(posedge clk);
      #1;
    end
    chk("hold_ready", 64'(ready), 64'd1);
    hold = res;
    chk("hold_result", res, {32'd1, 32'd2});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 chk("hold_stable", {res, 1'b0} | 65'(ready), {hold, 1'b0} | 65'd1);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1 chk("hold_drop", {62'd0, ready, busy}, 64'd0);
    chk("hold_keep", res, {32'd1, 32'd2});
    // annul mid-divide
    @(negedge clk);
    start = 1'b1;
    a = 32'd1000;
    b = 32'd3;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1 chk("annul_idle", {62'd0, ready, busy}, 64'd0);
    chk("annul_keep", res, {32'd1, 32'd2});
    @(negedge clk);
    annul = 1'b0;
    start = 1'b0;
    bad = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (ready || busy) bad = 1'b1;
    end
    chk("annul_quiet", 64'(bad), 64'd0);
    run('{1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0});
    // async reset between edges mid-divide
    @(negedge clk);
    start = 1'b1;
    a = 32'd1000;
    b = 32'd3;
    repeat (5) @(posedge clk);
    #1 chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1 chk("rst_async", {res[61:0], ready, busy}, 64'd0);
    chk("rst_res_hi", 64'(res[63:62]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    run('{1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0});
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
